simm30_dram_ctrl: RTL and testbench

- Responder side of the `m_addr`/`m_write`/`m_ena`/`m_busy`/`m_ack` memory handshake used by the busy-beaver tape engines.
- Converts one 8-bit read or write per request into RAS/CAS cycles on the 30-pin SIMM (TMS4464-class, 64K x 8 used).
- Owns power-up init and periodic CAS-before-RAS (CBR) refresh.
- Sits in `busy` between the beaver core and the SIMM pins. The top level drives `ram_dq` from `wr_data` whenever `ram_we_` = 0.

---
 rtl/simm30_dram_ctrl.sv | 155 +++++++++++++++
 tb/tb_simm30_dram_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/simm30_dram_ctrl.sv
// simm30_dram_ctrl: single-byte RAS/CAS access engine for a 64K x 8 30-pin SIMM with init and CBR refresh.
// Define DRAM_ACCESS_CNT_EN to add the acc_cnt/ref_cnt activity counters.
module simm30_dram_ctrl #(
    parameter int T_INIT_CYC   = 10000,
    parameter int N_INIT_REF   = 8,
    parameter int T_RAS_CYC    = 5,
    parameter int T_CAS_CYC    = 3,
    parameter int T_RP_CYC     = 4,
    parameter int REF_INTERVAL = 780
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        write,
    input  logic        ena,
    output logic [7:0]  rd_data,
    output logic        busy,
    output logic        ack,
    output logic [11:0] ram_addr,
    input  logic [7:0]  ram_dq,
`ifdef DRAM_ACCESS_CNT_EN
    output logic [31:0] acc_cnt,
    output logic [15:0] ref_cnt,
`endif
    output logic        ram_we_,
    output logic        ram_ras_,
    output logic        ram_cas_
);
    typedef enum logic [3:0] {
        INIT_WAIT, INIT_REF, IDLE, ROW, COL, PRE, REF_CAS, REF_RAS, REF_PRE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, dur;
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] init_left_q, init_left_d;
    logic [15:0] addr_q, addr_d;
    logic [11:0] ram_addr_q, ram_addr_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        ref_pend_q, ref_pend_d;
    logic        write_q, write_d;
    logic        busy_q, busy_d, ack_q, ack_d;
    logic        we_q, we_d, ras_q, ras_d, cas_q, cas_d;
    logic        last, in_init, tmr_wrap;

    always_comb begin
        dur = 16'd1;
        case (state_q)
            INIT_WAIT:     dur = 16'(T_INIT_CYC);
            ROW, REF_RAS:  dur = 16'(T_RAS_CYC);
            COL:           dur = 16'(T_CAS_CYC);
            PRE, REF_PRE:  dur = 16'(T_RP_CYC);
            default:       dur = 16'd1;
        endcase
        last        = cnt_q == dur - 16'd1;
        cnt_d       = last ? 16'd0 : cnt_q + 16'd1;
        state_d     = state_q;
        addr_d      = addr_q;
        write_d     = write_q;
        ack_d       = 1'b0;
        init_left_d = init_left_q;
        case (state_q)
            INIT_WAIT:         if (last) state_d = init_left_q != 16'd0 ? INIT_REF : IDLE;
            INIT_REF, REF_CAS: state_d = REF_RAS;
            REF_RAS:           if (last) state_d = REF_PRE;
            REF_PRE:           if (last) state_d = init_left_q != 16'd0 ? INIT_REF : IDLE;
            ROW:               if (last) state_d = COL;
            COL:               if (last) state_d = PRE;
            PRE:               if (last) state_d = IDLE;
            IDLE: begin
                // a due refresh always beats a request; ena stays pending until we come back
                if (ref_pend_q) begin
                    state_d = REF_CAS;
                end else if (ena) begin
                    state_d = ROW;
                    addr_d  = addr;
                    write_d = write;
                    ack_d   = 1'b1;
                end
            end
            default:           state_d = INIT_WAIT;
        endcase
        if (state_d == INIT_REF) init_left_d = init_left_q - 16'd1;
        // the init burst refreshes everything, so the periodic timer only starts once it is issued
        in_init    = init_left_q != 16'd0;
        tmr_wrap   = tmr_q == 16'(REF_INTERVAL - 1);
        tmr_d      = (in_init || tmr_wrap) ? 16'd0 : tmr_q + 16'd1;
        ref_pend_d = !in_init && (tmr_wrap || (ref_pend_q && state_d != REF_CAS));
        busy_d     = state_d != IDLE;
        ras_d      = !(state_d inside {ROW, COL, REF_RAS});
        cas_d      = !(state_d inside {COL, INIT_REF, REF_CAS, REF_RAS});
        we_d       = !(write_d && state_d inside {ROW, COL});
        ram_addr_d = state_d == ROW ? {4'b0, addr_d[7:0]} :
                     state_d == COL ? {4'b0, addr_d[15:8]} : ram_addr_q;
        rd_data_d  = (state_q == COL && last && !write_q) ? ram_dq : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT_WAIT;
            cnt_q       <= '0;
            tmr_q       <= '0;
            init_left_q <= 16'(N_INIT_REF);
            addr_q      <= '0;
            write_q     <= 1'b0;
            ref_pend_q  <= 1'b0;
            ram_addr_q  <= '0;
            rd_data_q   <= '0;
            busy_q      <= 1'b1;
            ack_q       <= 1'b0;
            we_q        <= 1'b1;
            ras_q       <= 1'b1;
            cas_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            init_left_q <= init_left_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            ref_pend_q  <= ref_pend_d;
            ram_addr_q  <= ram_addr_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            we_q        <= we_d;
            ras_q       <= ras_d;
            cas_q       <= cas_d;
        end
    end

`ifdef DRAM_ACCESS_CNT_EN
    logic [31:0] acc_cnt_q;
    logic [15:0] ref_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt_q <= '0;
            ref_cnt_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_q + 32'(ack_d);
            ref_cnt_q <= ref_cnt_q + 16'(state_d inside {INIT_REF, REF_CAS});
        end
    end
    assign acc_cnt = acc_cnt_q;
    assign ref_cnt = ref_cnt_q;
`endif

    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign ack      = ack_q;
    assign ram_addr = ram_addr_q;
    assign ram_we_  = we_q;
    assign ram_ras_ = ras_q;
    assign ram_cas_ = cas_q;
endmodule

// File: tb/tb_simm30_dram_ctrl.sv
// tb_simm30_dram_ctrl: random read/write traffic against a pin-level DRAM model and a byte scoreboard,
// plus init, refresh-collision, refresh-rate and reset-abort scenarios.
module tb_simm30_dram_ctrl;
    localparam int T_INIT  = 10000;
    localparam int N_INIT  = 8;
    localparam int T_RAS   = 5;
    localparam int T_CAS   = 3;
    localparam int T_RP    = 4;
    localparam int REF_INT = 780;
    localparam int REF_LEN = 1 + T_RAS + T_RP;
    // counted from the ack cycle, which is one cycle after the accept
    localparam int LAT     = T_RAS + T_CAS + T_RP + 1 - 1;

    logic        clk = 0, rst_n = 0, write = 0, ena = 0;
    logic [15:0] addr = 0;
    logic [7:0]  rd_data, dq = 0, wr_val = 0, exp_rd = 0;
    logic        busy, ack, ram_we_, ram_ras_, ram_cas_;
    logic [11:0] ram_addr;
`ifdef DRAM_ACCESS_CNT_EN
    logic [31:0] acc_cnt;
    logic [15:0] ref_cnt;
`endif

    simm30_dram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .write(write), .ena(ena),
        .rd_data(rd_data), .busy(busy), .ack(ack), .ram_addr(ram_addr), .ram_dq(dq),
`ifdef DRAM_ACCESS_CNT_EN
        .acc_cnt(acc_cnt), .ref_cnt(ref_cnt),
`endif
        .ram_we_(ram_we_), .ram_ras_(ram_ras_), .ram_cas_(ram_cas_)
    );

    always #10 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // DRAM pin model: latches row/col on strobe falls, stores wr_val on early-write CAS
    logic [7:0]  mem [65536];
    logic [11:0] row_a = 0, col_a = 0;
    logic        ras_p = 1, cas_p = 1, we_ras = 1, we_cas = 1;
    int          cyc = 0, cbr_cnt = 0, cbr_ras = 0, last_cbr = 0;
    always @(negedge clk) begin
        cyc   <= cyc + 1;
        ras_p <= ram_ras_;
        cas_p <= ram_cas_;
        if (ras_p && !ram_ras_ && ram_cas_) begin
            row_a  <= ram_addr;
            we_ras <= ram_we_;
        end
        if (ras_p && !ram_ras_ && !ram_cas_) cbr_ras <= cbr_ras + 1;
        if (cas_p && !ram_cas_ && ram_ras_) begin
            cbr_cnt  <= cbr_cnt + 1;
            last_cbr <= cyc;
        end
        if (cas_p && !ram_cas_ && !ram_ras_) begin
            col_a  <= ram_addr;
            we_cas <= ram_we_;
            if (!ram_we_) mem[{ram_addr[7:0], row_a[7:0]}] <= wr_val;
        end
        dq <= (!ram_ras_ && !ram_cas_ && ram_we_) ?
              mem[{(cas_p ? ram_addr[7:0] : col_a[7:0]), row_a[7:0]}] : 8'($urandom);
    end

    logic [7:0]  exp_mem [65536];
    logic [15:0] pool [8];
    int checks = 0, passes = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic finish_req(input logic [15:0] a, input logic w, input logic [7:0] v);
        int n;
        ena   = 0;
        addr  = 16'($urandom);
        write = 1'($urandom);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk("ack_pulse", ack, 0);
        end while (busy && n < 100);
        chk("latency", n, LAT);
        chk("row_addr", row_a, {4'b0, a[7:0]});
        chk("col_addr", col_a, {4'b0, a[15:8]});
        chk("we_at_ras", we_ras, !w);
        chk("we_at_cas", we_cas, !w);
        if (w) exp_mem[a] = v;
        else exp_rd = exp_mem[a];
        chk("rd_data", rd_data, exp_rd);
    endtask

    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] v);
        int n;
        addr = a; write = w; wr_val = v; ena = 1;
        n = 0;
        do begin tick(); n++; end while (!ack && n < 100);
        chk("ack_seen", ack, 1);
        chk("busy_at_ack", busy, 1);
        finish_req(a, w, v);
    endtask

    task automatic wait_cbr();
        int c, n;
        c = cbr_cnt;
        n = 0;
        do begin tick(); n++; end while (cbr_cnt == c && n < 1000);
        if (n >= 1000) chk("cbr_timeout", 0, 1);
    endtask

    task automatic run_init(input logic [15:0] a, input logic [7:0] v);
        int n, c0, c1;
        logic early;
        addr = a; write = 1; wr_val = v; ena = 1;
        c0 = cbr_cnt; c1 = cbr_ras;
        early = 0;
        rst_n = 1;
        n = 0;
        do begin tick(); n++; early |= ack; end while (busy && n < 20000);
        chk("init_busy_len", n, T_INIT + N_INIT * REF_LEN);
        chk("init_no_ack", early, 0);
        chk("init_cas_first", cbr_cnt - c0, N_INIT);
        chk("init_ras_after_cas", cbr_ras - c1, N_INIT);
        tick();
        chk("init_ack", ack, 1);
        finish_req(a, 1, v);
    endtask

    initial begin
        int n, c0, p;
        for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
        repeat (3) tick();
        chk("rst_busy", busy, 1);
        chk("rst_strobes", {ram_ras_, ram_cas_, ram_we_, ack}, 4'b1110);
        chk("rst_rd_addr", {rd_data, ram_addr}, 0);
        run_init(16'h12A5, 8'h3C);
        access(16'h12A5, 0, 0);
        chk("read_3c", rd_data, 8'h3C);
        access(16'h0001, 1, 8'hE7);
        chk("rd_hold_after_write", rd_data, 8'h3C);
        for (int i = 0; i < 24; i++)
            access(pool[$urandom_range(0, 7)], 1'($urandom), 8'($urandom));
        // collide a request with a refresh that is exactly one period away
        wait_cbr();
        wait_cbr();
        repeat (REF_INT - 1) tick();
        c0 = cbr_cnt;
        addr = 16'h12A5; write = 0; ena = 1;
        n = 0;
        do begin
            tick();
            n++;
            if (n == 1) chk("refresh_wins", {cbr_cnt - c0, 31'(ack)}, {32'd1, 31'd0});
        end while (!ack && n < 50);
        chk("ref_ack_delay", n, REF_LEN + 2);
        finish_req(16'h12A5, 0, 0);
        wait_cbr();
        wait_cbr();
        p = last_cbr;
        c0 = cbr_cnt;
        repeat (4000) begin
            tick();
            if (last_cbr != p) begin
                chk("ref_spacing", last_cbr - p, REF_INT);
                p = last_cbr;
            end
        end
        chk("ref_count_4000", cbr_cnt - c0, 5);
        addr = pool[0]; write = 0; ena = 1;
        n = 0;
        do begin tick(); n++; end while (!ack && n < 100);
        ena = 0;
        n = 0;
        do begin tick(); n++; end while (ram_cas_ && n < 20);
        chk("reached_col", {ram_ras_, ram_cas_}, 2'b00);
        #3 rst_n = 0;
        #1;
        chk("async_strobes", {ram_ras_, ram_cas_, ram_we_}, 3'b111);
        chk("async_busy_ack", {busy, ack}, 2'b10);
        chk("async_rd_addr", {rd_data, ram_addr}, 0);
        exp_rd = 0;
        repeat (3) tick();
        run_init(16'h0042, 8'h5A);
        access(16'h0042, 0, 0);
        chk("read_after_reinit", rd_data, 8'h5A);
        access(pool[1], 1, 8'h99);
`ifdef DRAM_ACCESS_CNT_EN
        chk("acc_cnt", acc_cnt, 3);
        chk("ref_cnt_ge8", ref_cnt >= 16'd8, 1);
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
